// File: rtl/mixsx_sched.sv
// rtl/mixsx_sched.sv - two-requester scheduler around a shared mixsx32 word-mix engine
//
// Arbitrates two job requesters round-robin, latches the winner's operands,
// pulses the engine clear, waits for the engine with a timeout, and returns
// the merged 64-bit result words tagged with the requester ID.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester request, one-hot acceptance pulse
//   req_c/req_x/req_d     requester operands, requester i at slice i
//   eng_clr               engine clear (reset or CLEAR state)
//   eng_c/eng_x/eng_d     latched operands driven to the engine
//   eng_cout/eng_rdy      engine result (low 32 bits of each word valid) and done
//   rsp_valid/rsp_ready   result handshake
//   rsp_id/rsp_cout/rsp_err  requester ID, merged result, timeout flag
//   busy                  scheduler is not idle
module mixsx_sched #(
    parameter int CWORDS64 = 2,
    parameter int XWORDS32 = 2,
    parameter int TIMEOUT  = 16,
    localparam int DW  = (XWORDS32 > 1) ? $clog2(XWORDS32) : 1,
    localparam int CW  = CWORDS64 * 64,
    localparam int XW  = XWORDS32 * 32,
    localparam int DVW = CWORDS64 * DW,
    localparam int TW  = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*CW-1:0] req_c,
    input  logic [2*XW-1:0] req_x,
    input  logic [2*DVW-1:0] req_d,
    output logic            eng_clr,
    output logic [CW-1:0]   eng_c,
    output logic [XW-1:0]   eng_x,
    output logic [DVW-1:0]  eng_d,
    input  logic [CW-1:0]   eng_cout,
    input  logic            eng_rdy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [CW-1:0]   rsp_cout,
    output logic            rsp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            last_grant;
    logic            grant;
    logic [TW-1:0]   timer;
    logic            timeout_hit;
    logic [CW-1:0]   merged;
    logic [CWORDS64*32-1:0] eng_hi_unused;

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    // The engine only computes the low half of each word; the upper half is
    // restored from the operand latched at grant time.
    always_comb begin
        merged        = '0;
        eng_hi_unused = '0;
        for (int k = 0; k < CWORDS64; k++) begin
            merged[k*64+32 +: 32]    = eng_c[k*64+32 +: 32];
            merged[k*64 +: 32]       = eng_cout[k*64 +: 32];
            eng_hi_unused[k*32 +: 32] = eng_cout[k*64+32 +: 32];
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        req_ready  = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    // On contention the requester that did not win last time goes.
                    grant      = (&req_valid) ? ~last_grant : req_valid[1];
                    state_next = CLEAR;
                    if (!reset) begin
                        req_ready = grant ? 2'b10 : 2'b01;
                    end
                end
            end
            CLEAR: state_next = RUN;
            RUN: begin
                if (eng_rdy || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            timer      <= '0;
            eng_c      <= '0;
            eng_x      <= '0;
            eng_d      <= '0;
            rsp_id     <= 1'b0;
            rsp_cout   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        eng_c      <= grant ? req_c[CW +: CW]   : req_c[0 +: CW];
                        eng_x      <= grant ? req_x[XW +: XW]   : req_x[0 +: XW];
                        eng_d      <= grant ? req_d[DVW +: DVW] : req_d[0 +: DVW];
                        rsp_id     <= grant;
                        last_grant <= grant;
                    end
                end
                CLEAR: timer <= '0;
                RUN: begin
                    timer <= timer + 1'b1;
                    // A ready engine takes priority over an expiring timer.
                    if (eng_rdy) begin
                        rsp_cout <= merged;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_cout <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_clr   = reset | (state == CLEAR);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mixsx_sched.sv
// tb/tb_mixsx_sched.sv - self-checking bench for mixsx_sched
module tb_mixsx_sched;

    localparam int CWORDS64 = 2;
    localparam int XWORDS32 = 2;
    localparam int TIMEOUT  = 16;
    localparam int CW = 128;
    localparam int XW = 64;
    localparam int DVW = 2;

    logic            clk;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*CW-1:0] req_c;
    logic [2*XW-1:0] req_x;
    logic [2*DVW-1:0] req_d;
    logic            eng_clr;
    logic [CW-1:0]   eng_c;
    logic [XW-1:0]   eng_x;
    logic [DVW-1:0]  eng_d;
    logic [CW-1:0]   eng_cout;
    logic            eng_rdy;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [CW-1:0]   rsp_cout;
    logic            rsp_err;
    logic            busy;

    mixsx_sched #(.CWORDS64(CWORDS64), .XWORDS32(XWORDS32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_c(req_c), .req_x(req_x), .req_d(req_d),
        .eng_clr(eng_clr), .eng_c(eng_c), .eng_x(eng_x), .eng_d(eng_d),
        .eng_cout(eng_cout), .eng_rdy(eng_rdy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0]  rc [2];
    logic [XW-1:0]  rx [2];
    logic [DVW-1:0] rd [2];
    logic           last_g;

    // Engine model: counts cycles since the clear pulse and raises ready
    // (held) once eng_delay cycles have elapsed; 0 means it never finishes.
    // Upper halves of each word are junk that the scheduler must discard.
    int eng_cnt   = 0;
    int eng_delay = 0;
    initial eng_rdy = 1'b0;
    initial eng_cout = '0;
    always @(negedge clk) begin
        if (eng_clr) eng_cnt = 0;
        else         eng_cnt = eng_cnt + 1;
        eng_rdy = (eng_delay > 0) && (eng_cnt >= eng_delay);
        for (int k = 0; k < CWORDS64; k++) begin
            eng_cout[k*64+32 +: 32] = $urandom;
            eng_cout[k*64 +: 32]    = eng_c[k*64 +: 32] ^ (eng_d[k] ? eng_x[63:32] : eng_x[31:0]);
        end
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        req_c = {rc[1], rc[0]};
        req_x = {rx[1], rx[0]};
        req_d = {rd[1], rd[0]};
    endtask

    // Each result word: upper half is the operand's, lower half is operand
    // low half XOR the x word selected by that word's index bit.
    function automatic logic [CW-1:0] merge(input logic [CW-1:0] c, input logic [XW-1:0] x,
                                            input logic [DVW-1:0] d);
        logic [CW-1:0] r;
        for (int k = 0; k < CWORDS64; k++) begin
            r[k*64+32 +: 32] = c[k*64+32 +: 32];
            r[k*64 +: 32]    = c[k*64 +: 32] ^ (d[k] ? x[63:32] : x[31:0]);
        end
        return r;
    endfunction

    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return ~last;
        return v[1];
    endfunction

    // Called at a falling edge with the scheduler idle; returns at a falling
    // edge with the scheduler idle again.
    task automatic do_job(input logic [1:0] vmask, input int delay, input int hold,
                          input bit mod, input logic exp_g, output logic [CW-1:0] got);
        logic [CW-1:0]  ec;
        logic [XW-1:0]  ex;
        logic [DVW-1:0] ed;
        logic [CW-1:0]  exp_c;
        bit             succ;
        int             lat;
        req_valid = vmask;
        rsp_ready = 1'b0;
        drive();
        eng_delay = delay;
        ec = rc[exp_g];
        ex = rx[exp_g];
        ed = rd[exp_g];
        succ  = (delay > 0) && (delay <= TIMEOUT);
        lat   = succ ? delay : TIMEOUT;
        exp_c = succ ? merge(ec, ex, ed) : '0;
        #1;
        chk("grant", CW'(req_ready), CW'(exp_g ? 2'b10 : 2'b01));
        last_g = exp_g;
        for (int k = 1; k <= 1 + lat; k++) begin
            @(negedge clk);
            chk("eng_clr", CW'(eng_clr), CW'(k == 1));
            chk("no_rsp", CW'(rsp_valid), '0);
            chk("no_grant_busy", CW'(req_ready), '0);
            if (k == 2) chk("eng_c_latched", eng_c, ec);
            if (mod && k == 3) begin
                rc[exp_g] = ~rc[exp_g];
                rx[exp_g] = ~rx[exp_g];
                rd[exp_g] = ~rd[exp_g];
                drive();
            end
        end
        @(negedge clk);
        chk("rsp_valid", CW'(rsp_valid), 1);
        chk("rsp_id", CW'(rsp_id), CW'(exp_g));
        chk("rsp_err", CW'(rsp_err), CW'(!succ));
        chk("rsp_cout", rsp_cout, exp_c);
        got = rsp_cout;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", CW'(rsp_valid), 1);
            chk("bp_cout", rsp_cout, exp_c);
            chk("bp_err", CW'(rsp_err), CW'(!succ));
            chk("bp_id", CW'(rsp_id), CW'(exp_g));
            chk("bp_no_grant", CW'(req_ready), '0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_drop", CW'(rsp_valid), '0);
        chk("idle", CW'(busy), '0);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0] vmask;
        int         delay;
        int         hold;
        bit         mod;
        logic       exp_id;
    } vec_t;

    vec_t tbl [9];
    logic [CW-1:0] got;

    initial begin
        tbl[0] = '{2'b11, 3,  0,  1'b0, 1'b1};
        tbl[1] = '{2'b11, 1,  0,  1'b0, 1'b0};
        tbl[2] = '{2'b11, 16, 0,  1'b0, 1'b1};
        tbl[3] = '{2'b11, 0,  0,  1'b0, 1'b0};
        tbl[4] = '{2'b11, 17, 0,  1'b0, 1'b1};
        tbl[5] = '{2'b11, 2,  10, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 5,  0,  1'b1, 1'b0};
        tbl[7] = '{2'b10, 4,  1,  1'b1, 1'b1};
        tbl[8] = '{2'b11, 6,  2,  1'b0, 1'b0};

        reset = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rc[i] = '0; rx[i] = '0; rd[i] = '0;
        end
        drive();
        repeat (2) @(negedge clk);
        chk("rst_eng_clr", CW'(eng_clr), 1);
        chk("rst_req_ready", CW'(req_ready), '0);
        chk("rst_rsp_valid", CW'(rsp_valid), '0);
        chk("rst_busy", CW'(busy), '0);
        chk("rst_rsp_cout", rsp_cout, '0);
        chk("rst_rsp_err", CW'(rsp_err), '0);
        chk("rst_rsp_id", CW'(rsp_id), '0);
        chk("rst_eng_c", eng_c, '0);
        reset = 1'b0;
        last_g = 1'b1;

        // Single job from requester 0 with fixed operands.
        rc[0] = {64'hAAAAAAAA_11111111, 64'hBBBBBBBB_22222222};
        rx[0] = {32'hFFFF0000, 32'h0000FFFF};
        rd[0] = 2'b10;
        do_job(2'b01, 5, 0, 1'b0, 1'b0, got);
        chk("t1_cout", got, {64'hAAAAAAAA_EEEE1111, 64'hBBBBBBBB_2222DDDD});

        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < 2; r++) begin
                rc[r] = {$urandom, $urandom, $urandom, $urandom};
                rx[r] = {$urandom, $urandom};
                rd[r] = DVW'($urandom);
            end
            do_job(tbl[i].vmask, tbl[i].delay, tbl[i].hold, tbl[i].mod, tbl[i].exp_id, got);
        end

        // Reset during the third RUN cycle discards the job.
        rc[0] = {$urandom, $urandom, $urandom, $urandom};
        drive();
        req_valid = 2'b01;
        eng_delay = 0;
        #1;
        chk("r6_grant", CW'(req_ready), CW'(2'b01));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("r6_eng_clr", CW'(eng_clr), 1);
        chk("r6_rsp_valid", CW'(rsp_valid), '0);
        chk("r6_busy", CW'(busy), '0);
        chk("r6_req_ready", CW'(req_ready), '0);
        chk("r6_rsp_cout", rsp_cout, '0);
        chk("r6_rsp_err", CW'(rsp_err), '0);
        chk("r6_eng_c", eng_c, '0);
        @(negedge clk);
        chk("r6_hold_valid", CW'(rsp_valid), '0);
        chk("r6_hold_clr", CW'(eng_clr), 1);
        reset = 1'b0;
        last_g = 1'b1;
        rc[1] = {$urandom, $urandom, $urandom, $urandom};
        do_job(2'b11, 3, 0, 1'b0, 1'b0, got);

        // Randomized jobs against the arbitration and merge model.
        for (int j = 0; j < 25; j++) begin
            logic [1:0] vm;
            int dl;
            for (int r = 0; r < 2; r++) begin
                rc[r] = {$urandom, $urandom, $urandom, $urandom};
                rx[r] = {$urandom, $urandom};
                rd[r] = DVW'($urandom);
            end
            vm = 2'($urandom_range(1, 3));
            dl = $urandom_range(0, TIMEOUT + 2);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 2'b00;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("idle_no_grant", CW'(req_ready), '0);
                    chk("idle_busy", CW'(busy), '0);
                end
            end
            do_job(vm, dl, $urandom_range(0, 3), (dl >= 4) && ($urandom_range(0, 1) == 1),
                   pick(vm, last_g), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mixsx_sched.md
Name: mixsx_sched

Overview:
- Shares one mixsx32 word-mix engine between two requesters.
- Round-robin arbitration, operand latching, per-job engine clear, completion wait with timeout, and result merge.
- The engine only produces the XORed low 32 bits of each 64-bit c word. The scheduler restores each upper half from the latched c and returns the full result with requester ID.

Parameters:
- CWORDS64, 2, number of 64-bit words in c.
- XWORDS32, 2, number of 32-bit words in x.
- TIMEOUT, 16, maximum RUN cycles to wait for eng_rdy; width of counter is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester job request.
- req_ready  out  2  one-hot acceptance pulse.
- req_c  in  2*CWORDS64*64  requester i operand at slice i.
- req_x  in  2*XWORDS32*32  requester i operand at slice i.
- req_d  in  2*CWORDS64*$clog2(XWORDS32)  requester i index vector at slice i.
- eng_clr  out  1  engine reset; = reset OR (state==CLEAR).
- eng_c  out  CWORDS64*64  latched c.
- eng_x  out  XWORDS32*32  latched x.
- eng_d  out  CWORDS64*$clog2(XWORDS32)  latched d.
- eng_cout  in  CWORDS64*64  engine result.
- eng_rdy  in  1  engine done.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the job.
- rsp_cout  out  CWORDS64*64  merged result.
- rsp_err  out  1  job timed out.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE; all outputs 0 except eng_clr=1; latched operands 0; last_grant=1, so requester 0 wins first.
- States: IDLE -> CLEAR -> RUN -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant one. When both are set, grant the requester != last_grant.
  - Assert req_ready[g] this cycle only (combinational, one-hot).
  - Latch req_c/x/d slice g and rsp_id<=g; last_grant<=g; go to CLEAR.
  - If no req_valid, stay in IDLE with req_ready=0.
- CLEAR:
  - eng_clr=1 for exactly one cycle; timer<=0; go to RUN.
- RUN:
  - eng_clr=0; timer increments each cycle.
  - First cycle eng_rdy=1:
    - For each word k, rsp_cout[k*64+32 +: 32] <= latched c upper half.
    - rsp_cout[k*64 +: 32] <= eng_cout[k*64 +: 32].
    - rsp_err<=0; go to RESP.
  - Else if timer==TIMEOUT-1: rsp_cout<=0; rsp_err<=1; go to RESP.
  - eng_rdy and timeout in the same cycle: eng_rdy wins, err=0.
- RESP:
  - rsp_valid=1; rsp_id/cout/err held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready go to IDLE; rsp_valid drops next cycle.
  - No new grant in the handshake cycle; earliest next req_ready is the following cycle.
- Latency: grant at cycle T, CLEAR at T+1, RUN from T+2, rsp_valid one cycle after the eng_rdy sample.
- Input changes:
  - Changes to req_* after the grant cycle do not affect the job.
  - req_valid deasserting while not granted is legal; no request is remembered.
- eng_rdy asserted during IDLE/CLEAR/RESP is ignored.
- Reset mid-job:
  - Job is discarded with no response; all state returns to reset values.
  - eng_clr is held high while reset is high.
- Width rules: slice i of req_c is req_c[i*CWORDS64*64 +: CWORDS64*64]; same pattern for x and d.

Test Plan:
1. Single job. Requester 0 only, CWORDS64=2, XWORDS32=2, with:
   - c={64'hAAAAAAAA_11111111, 64'hBBBBBBBB_22222222}
   - x={32'hFFFF0000, 32'h0000FFFF}
   - d=2'b10
   - engine model returns the XORed low halves with eng_rdy 5 cycles into RUN.
   -> req_ready=2'b01 for 1 cycle; eng_clr high 1 cycle; rsp_cout={64'hAAAAAAAA_EEEE1111, 64'hBBBBBBBB_2222DDDD}, rsp_id=0, rsp_err=0.
2. Contention. Both req_valid held high for 4 jobs -> grant order 0,1,0,1; rsp_id matches each grant.
3. Timeout. eng_rdy never asserted -> rsp_valid exactly TIMEOUT cycles after RUN entry; rsp_err=1, rsp_cout=0, then the next grant proceeds normally.
4. Backpressure. rsp_ready low for 10 cycles -> rsp_valid, rsp_cout and rsp_err stable; req_ready stays 0 while req_valid=2'b11; accept after rsp_ready rises.
5. Operand isolation. Change req_c of the granted requester during RUN -> result uses the grant-cycle value.
6. Reset mid-RUN. Assert reset at RUN cycle 2 -> all outputs at reset values, eng_clr=1, no rsp_valid. After release with both requesting, requester 0 is granted first.
